// File: rtl/shift_row_fwd.sv
// Forward AES ShiftRows: buffers a 16-byte column-major state, then streams it out row-rotated.
// First output is valid the cycle after the in_last transfer; out_ready=0 holds the output, and input stalls while draining.
module shift_row_fwd #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err
);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf [16];
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [3:0]       r_k;
  logic [3:0]       w_k_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_cnt_full;
  logic             w_frame_bad;
  logic             w_wr_en;
  logic [1:0]       w_row;
  logic [1:0]       w_src_col;
  logic [3:0]       w_src_idx;

  assign w_in_xfer   = in_valid & (r_state == S_FILL);
  assign w_out_xfer  = out_ready & (r_state == S_DRAIN);
  assign w_cnt_full  = (r_cnt == 4'd15);
  // in_last must coincide exactly with the 16th byte, otherwise the block is dropped
  assign w_frame_bad = in_last ^ w_cnt_full;
  assign w_wr_en     = w_in_xfer & ~w_frame_bad;

  // Row r is rotated left by r: source column wraps naturally in 2 bits
  assign w_row     = r_k[1:0];
  assign w_src_col = r_k[3:2] + w_row;
  assign w_src_idx = {w_src_col, w_row};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    w_err_nxt   = r_err;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (w_in_xfer) begin
          if (w_frame_bad) begin
            w_cnt_nxt = 4'd0;
            w_err_nxt = 1'b1;
          end else if (w_cnt_full) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_buf[w_src_idx];
        out_last  = (r_k == 4'd15);
        if (w_out_xfer) begin
          w_k_nxt = r_k + 4'd1;
          if (r_k == 4'd15) begin
            w_state_nxt = S_FILL;
          end
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_FILL;
      r_cnt   <= 4'd0;
      r_k     <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      r_buf[r_cnt] <= in_data;
    end
  end

  assign err = r_err;

endmodule
